// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants: datapath width, write-back result-select encodings
// and the hardwired-zero register index.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bundle plus the ID-stage read ports.
// The master is the pipeline side; the slave is the register file.
interface wb_regfile_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) ();

  logic            regWriteW;
  logic [1:0]      resultSrcW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ALUResultW;
  logic [XLEN-1:0] RDW;
  logic [XLEN-1:0] PCPlus4W;
  logic [XLEN-1:0] extImmW;
  logic [4:0]      A1D;
  logic [4:0]      A2D;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] resultW;
  logic            wbValidW;
  logic [31:0]     retireCnt;

  modport master (
    output regWriteW, resultSrcW, RdW, ALUResultW, RDW, PCPlus4W, extImmW, A1D, A2D,
    input  RD1D, RD2D, resultW, wbValidW, retireCnt
  );

  modport slave (
    input  regWriteW, resultSrcW, RdW, ALUResultW, RDW, PCPlus4W, extImmW, A1D, A2D,
    output RD1D, RD2D, resultW, wbValidW, retireCnt
  );

endinterface

// File: rtl/wb_result_mux.sv
// Write-back result selector; shared with the forwarding unit.
module wb_result_mux
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [1:0]      res_src_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] mem_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    result_o = alu_i;
    unique case (res_src_i)
      RES_ALU: result_o = alu_i;
      RES_MEM: result_o = mem_i;
      RES_PC4: result_o = pc4_i;
      RES_IMM: result_o = imm_i;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// WB-stage consumer: selects the result, commits it to the 32x32 integer register file,
// serves the two ID read ports with optional same-cycle bypass, and counts retired writes.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned NREGS  = riscv_pkg::NREGS,
  parameter bit          BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic [XLEN-1:0] result;
  logic            wb_valid;

  wb_result_mux #(
    .XLEN (XLEN)
  ) u_result_mux (
    .res_src_i (bus.resultSrcW),
    .alu_i     (bus.ALUResultW),
    .mem_i     (bus.RDW),
    .pc4_i     (bus.PCPlus4W),
    .imm_i     (bus.extImmW),
    .result_o  (result)
  );

  assign wb_valid = bus.regWriteW && (bus.RdW != REG_ZERO);

  always_comb begin
    regs_d       = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (wb_valid) begin
      regs_d[bus.RdW] = result;
      retire_cnt_d    = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      retire_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // x0 and held reset read as zero even when the bypass would match.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    if (!rst || idx == REG_ZERO) begin
      return '0;
    end else if (BYPASS && wb_valid && (bus.RdW == idx)) begin
      return result;
    end else begin
      return regs_q[idx];
    end
  endfunction

  always_comb begin
    bus.RD1D = read_port(bus.A1D);
    bus.RD2D = read_port(bus.A2D);
  end

  assign bus.resultW   = result;
  assign bus.wbValidW  = wb_valid;
  assign bus.retireCnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: bypassed and non-bypassed instances share one stimulus stream and
// are compared every cycle against an array-based architectural model, plus literal checks.
module tb_wb_regfile;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        reg_write;
  logic [1:0]  res_src;
  logic [4:0]  rd, a1, a2;
  logic [31:0] alu, mem, pc4, imm;

  wb_regfile_if bus_b ();
  wb_regfile_if bus_n ();

  assign bus_b.regWriteW  = reg_write;
  assign bus_b.resultSrcW = res_src;
  assign bus_b.RdW        = rd;
  assign bus_b.ALUResultW = alu;
  assign bus_b.RDW        = mem;
  assign bus_b.PCPlus4W   = pc4;
  assign bus_b.extImmW    = imm;
  assign bus_b.A1D        = a1;
  assign bus_b.A2D        = a2;
  assign bus_n.regWriteW  = reg_write;
  assign bus_n.resultSrcW = res_src;
  assign bus_n.RdW        = rd;
  assign bus_n.ALUResultW = alu;
  assign bus_n.RDW        = mem;
  assign bus_n.PCPlus4W   = pc4;
  assign bus_n.extImmW    = imm;
  assign bus_n.A1D        = a1;
  assign bus_n.A2D        = a2;

  wb_regfile #(.BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  wb_regfile #(.BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Architectural model: contents of x1..x31 and the number of committed writes.
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  function automatic logic [31:0] m_result();
    case (res_src)
      2'd0:    return alu;
      2'd1:    return mem;
      2'd2:    return pc4;
      default: return imm;
    endcase
  endfunction

  function automatic bit m_valid();
    return reg_write && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
    if (!rst || idx == 5'd0) return 32'd0;
    if (byp && m_valid() && rd == idx) return m_result();
    return m_regs[idx];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (m_valid()) begin
      m_regs[rd] = m_result();
      m_cnt      = m_cnt + 32'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("b_resultW",  bus_b.resultW,   m_result());
      check("n_resultW",  bus_n.resultW,   m_result());
      check("b_wbValidW", {31'd0, bus_b.wbValidW}, {31'd0, m_valid()});
      check("n_wbValidW", {31'd0, bus_n.wbValidW}, {31'd0, m_valid()});
      check("b_RD1D",     bus_b.RD1D,      m_read(a1, 1'b1));
      check("b_RD2D",     bus_b.RD2D,      m_read(a2, 1'b1));
      check("n_RD1D",     bus_n.RD1D,      m_read(a1, 1'b0));
      check("n_RD2D",     bus_n.RD2D,      m_read(a2, 1'b0));
      check("b_retire",   bus_b.retireCnt, m_cnt);
      check("n_retire",   bus_n.retireCnt, m_cnt);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] exp_src [4];

  initial begin
    exp_src   = '{32'h11, 32'h22, 32'h33, 32'h44};
    reg_write = 1'b0; res_src = 2'd0; rd = 5'd0; a1 = 5'd5; a2 = 5'd31;
    alu = 32'd0; mem = 32'd0; pc4 = 32'd0; imm = 32'd0;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_hold_rd1", bus_b.RD1D, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rd1", bus_b.RD1D, 32'd0);
    check("rst_rd2", bus_n.RD2D, 32'd0);
    check("rst_cnt", bus_n.retireCnt, 32'd0);

    // Result select stepped over four writes to x3.
    #1 reg_write = 1'b1; rd = 5'd3; alu = 32'h11; mem = 32'h22; pc4 = 32'h33; imm = 32'h44;
    a1 = 5'd3; a2 = 5'd3;
    for (int i = 0; i < 4; i++) begin
      res_src = 2'(i);
      @(negedge clk);
      check("src_sel_x3", bus_n.RD1D, exp_src[i]);
      #1;
    end
    check("src_cnt", bus_n.retireCnt, 32'd4);

    // x0 writes dropped.
    rd = 5'd0; alu = 32'hDEAD_BEEF; res_src = 2'd0; a1 = 5'd0;
    #1 check("x0_valid", {31'd0, bus_b.wbValidW}, 32'd0);
    check("x0_byp_rd", bus_b.RD1D, 32'd0);
    @(negedge clk);
    check("x0_rd", bus_n.RD1D, 32'd0);
    check("x0_cnt", bus_n.retireCnt, 32'd4);

    // Bypass: x7 = 5, then rewrite with 0xA5A5 while reading x7 on both ports.
    #1 rd = 5'd7; alu = 32'h5; a1 = 5'd7; a2 = 5'd7;
    @(negedge clk);
    #1 alu = 32'hA5A5;
    #1 check("byp_rd1", bus_b.RD1D, 32'hA5A5);
    check("byp_rd2", bus_b.RD2D, 32'hA5A5);
    check("nobyp_rd1_old", bus_n.RD1D, 32'h5);
    check("nobyp_rd2_old", bus_n.RD2D, 32'h5);
    @(negedge clk);
    check("nobyp_rd1_new", bus_n.RD1D, 32'hA5A5);
    check("nobyp_rd2_new", bus_n.RD2D, 32'hA5A5);

    // Write enable low.
    #1 reg_write = 1'b0; rd = 5'd9; alu = 32'h99; a1 = 5'd9;
    #1 check("gate_valid", {31'd0, bus_b.wbValidW}, 32'd0);
    check("gate_byp_rd", bus_b.RD1D, 32'd0);
    @(negedge clk);
    check("gate_rd", bus_n.RD1D, 32'd0);
    check("gate_cnt", bus_n.retireCnt, 32'd6);

    // Counter wrap.
    #1 force dut_n.retire_cnt_q = 32'hFFFF_FFFF;
    force dut_b.retire_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut_n.retire_cnt_q;
    release dut_b.retire_cnt_q;
    reg_write = 1'b1; rd = 5'd12; alu = 32'h1234; a1 = 5'd12; a2 = 5'd0;
    @(negedge clk);
    check("wrap_cnt_n", bus_n.retireCnt, 32'd0);
    check("wrap_cnt_b", bus_b.retireCnt, 32'd0);
    check("wrap_x12", bus_n.RD1D, 32'h1234);

    // Asynchronous reset between edges, with a write pending across it.
    #1 reg_write = 1'b0;
    #1 rst = 1'b0;
    #1 check("arst_x12_n", bus_n.RD1D, 32'd0);
    check("arst_x12_b", bus_b.RD1D, 32'd0);
    check("arst_cnt", bus_n.retireCnt, 32'd0);
    reg_write = 1'b1;
    #1 check("arst_valid_comb", {31'd0, bus_b.wbValidW}, 32'd1);
    check("arst_result_comb", bus_b.resultW, 32'h1234);
    @(negedge clk);
    check("arst_write_dropped", bus_n.RD1D, 32'd0);
    #1 rst = 1'b1; alu = 32'h77;
    @(negedge clk);
    check("post_rst_x12", bus_n.RD1D, 32'h77);
    check("post_rst_cnt", bus_n.retireCnt, 32'd1);

    #1 reg_write = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
